// File: rtl/egg_timer_pkg.sv
// Shared constants for the egg timer display path: segment patterns,
// digit count and the all-anodes-off value.
package egg_timer_pkg;

  localparam int          DIGIT_COUNT = 4;
  localparam logic [7:0]  AN_OFF      = 8'hFF;

  // Active-low cathodes, bit 0 = segment a .. bit 6 = segment g
  localparam logic [6:0]  SEG_0     = 7'b1000000;
  localparam logic [6:0]  SEG_1     = 7'b1111001;
  localparam logic [6:0]  SEG_2     = 7'b0100100;
  localparam logic [6:0]  SEG_3     = 7'b0110000;
  localparam logic [6:0]  SEG_4     = 7'b0011001;
  localparam logic [6:0]  SEG_5     = 7'b0010010;
  localparam logic [6:0]  SEG_6     = 7'b0000010;
  localparam logic [6:0]  SEG_7     = 7'b1111000;
  localparam logic [6:0]  SEG_8     = 7'b0000000;
  localparam logic [6:0]  SEG_9     = 7'b0010000;
  localparam logic [6:0]  SEG_DASH  = 7'b0111111;
  localparam logic [6:0]  SEG_BLANK = 7'b1111111;

endpackage

// File: rtl/bcd_to_seg.sv
// Combinational BCD digit to active-low seven-segment pattern; non-decimal
// codes show a dash.
module bcd_to_seg
  import egg_timer_pkg::*;
(
  input  logic [3:0] bcd,
  output logic [6:0] seg
);

  // Pattern lookup
  always_comb begin
    seg = SEG_DASH;
    case (bcd)
      4'd0:    seg = SEG_0;
      4'd1:    seg = SEG_1;
      4'd2:    seg = SEG_2;
      4'd3:    seg = SEG_3;
      4'd4:    seg = SEG_4;
      4'd5:    seg = SEG_5;
      4'd6:    seg = SEG_6;
      4'd7:    seg = SEG_7;
      4'd8:    seg = SEG_8;
      4'd9:    seg = SEG_9;
      default: seg = SEG_DASH;
    endcase
  end

endmodule

// File: rtl/seg_scan.sv
// Four-digit multiplexed seven-segment scanner with frame capture and blink.
// Optional macro SEG_LEADING_ZERO_BLANK_EN blanks a zero minute_tens digit.
module seg_scan
  import egg_timer_pkg::*;
#(
  parameter int REFRESH_DIV = 200000,
  parameter int BLINK_TICKS = 250
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] second_ones,
  input  logic [3:0] second_tens,
  input  logic [3:0] minute_ones,
  input  logic [3:0] minute_tens,
  input  logic       done,
  output logic [7:0] an,
  output logic [6:0] seg,
  output logic       dp
);

  localparam int PRE_W = $clog2(REFRESH_DIV);
  localparam int BLK_W = $clog2(BLINK_TICKS + 1);
  localparam int IDX_W = $clog2(DIGIT_COUNT);

  logic [PRE_W-1:0] pre_cnt_r;
  logic [IDX_W-1:0] idx_r;
  logic [15:0]      frame_r;
  logic             done_r;
  logic [BLK_W-1:0] blink_cnt_r;
  logic             blink_on_r;

  logic             tick_s;
  logic             capture_s;
  logic [3:0]       digit_s;
  logic [6:0]       dec_seg_s;
  logic             blank_s;
  logic [7:0]       an_s;
  logic             dp_s;

  assign tick_s    = (pre_cnt_r == PRE_W'(REFRESH_DIV - 1));
  // Only the tick that wraps the index back to 0 samples the inputs
  assign capture_s = tick_s && (idx_r == IDX_W'(DIGIT_COUNT - 1));

  // Prescaler, digit index, frame capture and blink timing
  always_ff @(posedge clk) begin
    if (reset) begin
      pre_cnt_r   <= '0;
      idx_r       <= '0;
      frame_r     <= 16'h0000;
      done_r      <= 1'b0;
      blink_cnt_r <= '0;
      blink_on_r  <= 1'b1;
    end else begin
      if (tick_s) begin
        pre_cnt_r <= '0;
        idx_r     <= idx_r + IDX_W'(1);
      end else begin
        pre_cnt_r <= pre_cnt_r + PRE_W'(1);
      end
      if (capture_s) begin
        frame_r <= {minute_tens, minute_ones, second_tens, second_ones};
        done_r  <= done;
      end
      if (capture_s && !done) begin
        blink_cnt_r <= '0;
        blink_on_r  <= 1'b1;
      end else if (tick_s && done_r) begin
        if (blink_cnt_r == BLK_W'(BLINK_TICKS - 1)) begin
          blink_cnt_r <= '0;
          blink_on_r  <= ~blink_on_r;
        end else begin
          blink_cnt_r <= blink_cnt_r + BLK_W'(1);
        end
      end
    end
  end

  // Select the frame digit for the active slot
  always_comb begin
    digit_s = 4'h0;
    case (idx_r)
      2'd0:    digit_s = frame_r[3:0];
      2'd1:    digit_s = frame_r[7:4];
      2'd2:    digit_s = frame_r[11:8];
      2'd3:    digit_s = frame_r[15:12];
      default: digit_s = 4'h0;
    endcase
  end

  bcd_to_seg u_bcd_to_seg (
    .bcd (digit_s),
    .seg (dec_seg_s)
  );

  // Next display values: anode select, blanking and separator
  always_comb begin
    blank_s = 1'b0;
    an_s    = AN_OFF;
    dp_s    = 1'b1;
    if (done_r && !blink_on_r) begin
      blank_s = 1'b1;
    end else begin
      blank_s = 1'b0;
    end
`ifdef SEG_LEADING_ZERO_BLANK_EN
    if ((idx_r == 2'd3) && (frame_r[15:12] == 4'h0)) begin
      blank_s = 1'b1;
    end else begin
      blank_s = blank_s;
    end
`endif
    if (blank_s) begin
      an_s = AN_OFF;
      dp_s = 1'b1;
    end else begin
      an_s = AN_OFF & ~(8'h01 << idx_r);
      dp_s = (idx_r == 2'd2) ? 1'b0 : 1'b1;
    end
  end

  // Registered display outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      an  <= AN_OFF;
      seg <= SEG_BLANK;
      dp  <= 1'b1;
    end else begin
      an  <= an_s;
      seg <= dec_seg_s;
      dp  <= dp_s;
    end
  end

endmodule

// File: tb/tb_seg_scan.sv
// Randomised bench for seg_scan against a tick/frame-level reference model.
module tb_seg_scan;

  localparam int RD = 4;
  localparam int BT = 2;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] second_ones, second_tens, minute_ones, minute_tens;
  logic       done;
  logic [7:0] an;
  logic [6:0] seg;
  logic       dp;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  seg_scan #(.REFRESH_DIV(RD), .BLINK_TICKS(BT)) dut (
    .clk         (clk),
    .reset       (reset),
    .second_ones (second_ones),
    .second_tens (second_tens),
    .minute_ones (minute_ones),
    .minute_tens (minute_tens),
    .done        (done),
    .an          (an),
    .seg         (seg),
    .dp          (dp)
  );

  task automatic check_val(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [6:0] ref_seg(input logic [3:0] d);
    case (d)
      4'd0:    ref_seg = 7'b1000000;
      4'd1:    ref_seg = 7'b1111001;
      4'd2:    ref_seg = 7'b0100100;
      4'd3:    ref_seg = 7'b0110000;
      4'd4:    ref_seg = 7'b0011001;
      4'd5:    ref_seg = 7'b0010010;
      4'd6:    ref_seg = 7'b0000010;
      4'd7:    ref_seg = 7'b1111000;
      4'd8:    ref_seg = 7'b0000000;
      4'd9:    ref_seg = 7'b0010000;
      default: ref_seg = 7'b0111111;
    endcase
  endfunction

  // Reference model: counts cycles since reset, derives ticks and frames
  int         m_cyc, m_ticks, m_bn;
  logic [3:0] m_frame [4];
  logic       m_cdone;
  logic       m_valid = 1'b0;
  logic [7:0] e_an;
  logic [6:0] e_seg;
  logic       e_dp;
  logic       e_seg_chk;

  initial begin : model
    int  idx;
    bit  blank;
    forever begin
      @(posedge clk);
      if (reset) begin
        m_cyc = 0; m_ticks = 0; m_bn = 0; m_cdone = 1'b0;
        for (int i = 0; i < 4; i++) m_frame[i] = 4'h0;
        e_an = 8'hFF; e_seg = 7'h7F; e_dp = 1'b1; e_seg_chk = 1'b1;
        m_valid = 1'b1;
      end else if (m_valid) begin
        idx   = m_ticks % 4;
        blank = m_cdone && (((m_bn / BT) % 2) == 1);
`ifdef SEG_LEADING_ZERO_BLANK_EN
        if (idx == 3 && m_frame[3] == 4'h0) blank = 1'b1;
`endif
        if (blank) begin
          e_an = 8'hFF; e_dp = 1'b1; e_seg_chk = 1'b0;
        end else begin
          e_an = 8'hFF & ~(8'h01 << idx);
          e_seg = ref_seg(m_frame[idx]);
          e_dp = (idx == 2) ? 1'b0 : 1'b1;
          e_seg_chk = 1'b1;
        end
        if ((m_cyc % RD) == RD - 1) begin
          if (m_cdone) m_bn++;
          m_ticks++;
          if ((m_ticks % 4) == 0) begin
            m_frame[0] = second_ones; m_frame[1] = second_tens;
            m_frame[2] = minute_ones; m_frame[3] = minute_tens;
            m_cdone = done;
            if (!done) m_bn = 0;
          end
        end
        m_cyc++;
      end
    end
  end

  // Compare on the falling edge, away from the active edge
  initial begin : checker_proc
    forever begin
      @(negedge clk);
      if (m_valid) begin
        check_val("an", an, e_an);
        check_val("dp", {7'd0, dp}, {7'd0, e_dp});
        if (e_seg_chk) check_val("seg", {1'b0, seg}, {1'b0, e_seg});
      end
    end
  end

  task automatic run(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic set_in(input logic [3:0] mt, input logic [3:0] mo,
                        input logic [3:0] st, input logic [3:0] so, input logic d);
    minute_tens = mt; minute_ones = mo; second_tens = st; second_ones = so; done = d;
  endtask

  initial begin : stim
    reset = 1'b1;
    set_in(4'd0, 4'd0, 4'd0, 4'd0, 1'b0);
    run(3);
    reset = 1'b0;
    set_in(4'd4, 4'd3, 4'd2, 4'd1, 1'b0);
    run(40);
    run(9);
    second_ones = 4'd7;
    run(40);
    second_ones = 4'hC;
    run(24);
    set_in(4'd0, 4'd0, 4'd0, 4'd0, 1'b1);
    run(80);
    done = 1'b0;
    run(40);
    set_in(4'd0, 4'd5, 4'd3, 4'd9, 1'b0);
    run(24);
    for (int k = 0; k < 40; k++) begin
      set_in(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
             4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
             ($urandom_range(0, 2) == 0));
      if ($urandom_range(0, 11) == 0) begin
        reset = 1'b1;
        run($urandom_range(1, 3));
        reset = 1'b0;
      end
      run($urandom_range(1, 30));
    end
    run(8);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
